boolexp_sweep_ctrl: RTL
=======================

# boolexp_sweep_ctrl

Self-checking sweep controller for a 3-input combinational Boolean block with ports a, b, c and y. On a start request it drives all eight input combinations in ascending order and holds each one for a fixed number of cycles. At the end of each hold it samples y and builds the observed 8-entry truth table. It then compares that table against an expected table supplied at start and reports pass/fail with a one-cycle done pulse. It replaces hand-written per-vector stimulus when exercising Boolean-expression blocks on the bench or on the board.

## Interface
- HOLD_CYCLES, default 4: cycles each input vector is held before y is captured; legal range is 1 and up.
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset; takes effect only on a rising edge of clk.
- start  input  1  sweep request; acted on only in IDLE.
- abort  input  1  synchronous abort of a running sweep.
- expected  input  8  expected truth table; bit i is the expected y for {a,b,c} = i; latched at start.
- y  input  1  output of the block under control.
- a, b, c  output  1 each  drive to the block under control; {a,b,c} = current vector index, with a as MSB.
- busy  output  1  high while a sweep is running.
- done  output  1  one-cycle pulse when a sweep completes; never asserted after an abort.
- pass  output  1  1 when the last completed sweep had no mismatches.
- table  output  8  observed truth table; bit i is the captured y for vector i.
- mismatch  output  8  bit i = table[i] XOR expected[i].

## Operation
- States:
  - IDLE: a,b,c = 0; busy = 0. start = 1 latches expected, clears table and mismatch, clears pass, sets idx = 0 and cnt = 0, and moves to RUN.
  - RUN: a,b,c = idx; busy = 1. cnt increments by 1 every cycle.
    - On the edge where cnt == HOLD_CYCLES-1: table[idx] <= y and mismatch[idx] <= y ^ expected_latched[idx].
    - On that same edge, if idx == 7, move to DONE; otherwise idx <= idx+1 and cnt <= 0.
  - DONE: lasts exactly one cycle. done = 1, busy = 0, a,b,c = 0. pass = (mismatch == 0), registered. Next state is IDLE.
- Counters:
  - idx is 3 bits and never wraps within a sweep.
  - cnt is wide enough to hold HOLD_CYCLES-1, with a minimum width of 1 bit.
  - With HOLD_CYCLES = 1, y is captured on every edge in RUN.
- Result retention: table, mismatch and pass hold their values through IDLE until the next accepted start. pass is updated only in DONE.
- start while in RUN or DONE is ignored; it is not queued.
- abort:
  - In RUN, abort moves the block to IDLE on the next edge. busy falls, done is not asserted and pass stays 0.
  - table and mismatch keep the partial results captured so far.
  - In IDLE or DONE, abort has no effect.
  - If abort and the final capture happen on the same edge, abort wins: the block goes to IDLE, the capture for vector 7 is discarded and done is not asserted.
- Changes on expected after the start edge have no effect on the running sweep.
- Reset, asserted at any time including mid-sweep: next edge forces IDLE. All outputs go to 0: a, b, c, busy, done, pass, table = 8'h00 and mismatch = 8'h00. Internal idx and cnt also go to 0. Reset has priority over start and abort.

## Timing
- All outputs are registered; there is no combinational path from any input to any output.
- start is sampled at edge E0:
  - busy = 1 and vector 0 is driven from E0 through E0+HOLD_CYCLES.
  - Vector i is driven from E0+i·H to E0+(i+1)·H, where H = HOLD_CYCLES.
  - y is sampled at edge E0+(i+1)·H, after H full cycles of settling.
- Final capture is at edge E0+8H. busy falls and done and pass become valid at that edge.
- done falls at E0+8H+1. The earliest next start is accepted at E0+8H+1, i.e. in the cycle after DONE.
- Total sweep: 8H cycles busy, plus 1 cycle done.

## Test plan
- Reset check: assert rst mid-sweep (H = 4, idx = 3) for 1 cycle -> next cycle all outputs are 0 and the state is IDLE. A following start runs a full clean sweep.
- Pass sweep: H = 4, bench model y = (a&b)|c, expected = 8'hEA, pulse start -> the a,b,c sequence is 0..7 with each vector held 4 cycles. busy is high for 32 cycles. table = 8'hEA, mismatch = 8'h00, and done pulses for 1 cycle with pass = 1.
- Fail sweep: same model, expected = 8'hE8 -> table = 8'hEA, mismatch = 8'h02, done pulses with pass = 0.
- H = 1: model y = a^b^c, expected = 8'h96 -> busy is high for exactly 8 cycles, table = 8'h96, pass = 1.
- Abort: H = 4, assert abort while idx = 5 -> the next edge gives IDLE with busy = 0. No done pulse occurs, pass = 0, and table[7:5] = 0 while bits 4:0 hold the captured values.
- Ignored inputs: pulse start again and change expected during RUN -> timing and results are identical to the pass sweep.

Source files
------------

// File: rtl/boolexp_sweep_ctrl_if.sv
// Handshake/result bundle between the sweep controller and its driver.
// Carries the sweep request, abort, expected table, y return path,
// the a/b/c drive and the registered status/result outputs.
interface boolexp_sweep_ctrl_if;
   logic       start_i;
   logic       abort_i;
   logic [7:0] expected_i;
   logic       y_i;
   logic       a_o;
   logic       b_o;
   logic       c_o;
   logic       busy_o;
   logic       done_o;
   logic       pass_o;
   logic [7:0] table_o;
   logic [7:0] mismatch_o;

   // Controller side
   modport slave (
      input  start_i, abort_i, expected_i, y_i,
      output a_o, b_o, c_o, busy_o, done_o, pass_o, table_o, mismatch_o
   );

   // Driver / bench side
   modport master (
      output start_i, abort_i, expected_i, y_i,
      input  a_o, b_o, c_o, busy_o, done_o, pass_o, table_o, mismatch_o
   );
endinterface

// File: rtl/boolexp_sweep_ctrl.sv
// Sweeps {a,b,c} through 0..7, holds each HOLD_CYCLES cycles, captures y and
// compares the observed truth table with the expected one latched at start.
// Sweep takes 8*HOLD_CYCLES busy cycles plus one done cycle; no backpressure.
module boolexp_sweep_ctrl #(
   parameter int HOLD_CYCLES = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   boolexp_sweep_ctrl_if.slave   bus
);

   localparam int            CW       = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [2:0]    idx_q,   idx_d;
   logic [CW-1:0] cnt_q,   cnt_d;
   logic [7:0]    exp_q,   exp_d;
   logic [7:0]    tbl_q,   tbl_d;
   logic [7:0]    mis_q,   mis_d;
   logic          pass_q,  pass_d;

   // State and result registers; reset clears everything to zero
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         cnt_q   <= '0;
         exp_q   <= '0;
         tbl_q   <= '0;
         mis_q   <= '0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         exp_q   <= exp_d;
         tbl_q   <= tbl_d;
         mis_q   <= mis_d;
         pass_q  <= pass_d;
      end
   end

   // Next-state, counters and capture; abort outranks a capture on the same edge
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      exp_d   = exp_q;
      tbl_d   = tbl_q;
      mis_d   = mis_q;
      pass_d  = pass_q;
      case (state_q)
         S_IDLE: begin
            if (bus.start_i) begin
               exp_d   = bus.expected_i;
               tbl_d   = '0;
               mis_d   = '0;
               pass_d  = 1'b0;
               idx_d   = '0;
               cnt_d   = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (bus.abort_i) begin
               idx_d   = '0;
               cnt_d   = '0;
               state_d = S_IDLE;
            end else if (cnt_q == CNT_LAST) begin
               tbl_d[idx_q] = bus.y_i;
               mis_d[idx_q] = bus.y_i ^ exp_q[idx_q];
               cnt_d        = '0;
               if (idx_q == 3'd7) begin
                  // pass becomes visible together with done, so it includes vector 7
                  pass_d  = (mis_d == 8'h00);
                  idx_d   = '0;
                  state_d = S_DONE;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_DONE: begin
            idx_d   = '0;
            cnt_d   = '0;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Outputs decode from registers only, so no input reaches an output combinationally
   always_comb begin
      bus.busy_o     = (state_q == S_RUN);
      bus.done_o     = (state_q == S_DONE);
      bus.a_o        = (state_q == S_RUN) & idx_q[2];
      bus.b_o        = (state_q == S_RUN) & idx_q[1];
      bus.c_o        = (state_q == S_RUN) & idx_q[0];
      bus.pass_o     = pass_q;
      bus.table_o    = tbl_q;
      bus.mismatch_o = mis_q;
   end

endmodule
